flex_round_counter: RTL and testbench
=====================================

// Module: flex_round_counter
// PURPOSE
//  Parametrised round sequencer for the cipher datapath. Latches a round count at start,
//  counts up (encrypt) or down (decrypt) one round per enabled cycle, flags first/last
//  round, and signals completion with a done pulse plus a sticky rollover flag. Sits
//  between the key-schedule/round controller and the round datapath. Supports 10/12/14-
//  round key sizes without RTL changes.
// PARAMETERS
//  WIDTH       4   bit width of round_count / rollover_val
//  MAX_ROUNDS  14  largest legal round count; must satisfy MAX_ROUNDS <= 2**WIDTH-1
// PORTS
//  clk           in   1      system clock, all state changes on rising edge
//  rst           in   1      asynchronous, active-high reset
//  clear         in   1      synchronous abort to IDLE
//  start         in   1      begin a sequence (sampled only in IDLE)
//  dir           in   1      0 = count up (encrypt), 1 = count down (decrypt); latched at start
//  rollover_val  in   WIDTH  terminal round number; latched at start
//  count_enable  in   1      advance one round this cycle (0 = stall, count held)
//  round_count   out  WIDTH  current round index
//  first_round   out  1      RUN and count at start value (up: 0; down: latched rv)
//  last_round    out  1      RUN and count at terminal value (up: latched rv; down: 0)
//  busy          out  1      1 in RUN or DONE
//  done          out  1      one-cycle pulse, high in DONE state
//  cnt_rollover  out  1      sticky: set entering DONE, cleared on accepted start or clear
//  cfg_err       out  1      only when ROUND_CNT_ERR_EN defined (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst=1, async): state=IDLE, round_count=0, cnt_rollover=0, done=0, busy=0,
//    cfg_err=0; first_round/last_round=0. Registers: state, round_count, rv_reg, dir_reg,
//    cnt_rollover, cfg_err. first_round/last_round/busy/done decode from registered state.
//  - Priority per cycle: rst > clear > start/count logic.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: start=1 -> latch rv_reg=min(rollover_val,MAX_ROUNDS), dir_reg=dir;
//          round_count <= (dir ? rv_reg : 0); cnt_rollover <= 0; go RUN. Latency 1 cycle.
//    RUN: count_enable=0 -> hold. count_enable=1 and not at terminal -> +1 (up) / -1 (down).
//         count_enable=1 at terminal -> go DONE, round_count held, cnt_rollover <= 1.
//    DONE: done=1 for exactly one cycle; unconditionally -> IDLE, round_count <= 0.
//  - start in RUN or DONE is ignored; it does not restart or extend the sequence.
//  - rollover_val=0: start value is terminal; one enabled cycle reaches DONE.
//  - Arithmetic stays in WIDTH bits; no wrap occurs since terminal is checked before step.
//  - clear in any state: -> IDLE, round_count=0, cnt_rollover=0, no done pulse; clear with
//    start in same cycle: clear wins, start dropped.
//  - Up, rv=R, count_enable held 1, start at cycle N: round_count 0..R on N+1..N+R+1,
//    done at N+R+2, busy falls at N+R+3.
// CONFIGURATION
//  ROUND_CNT_ERR_EN defined: rollover_val > MAX_ROUNDS at start rejects the start (stay
//    IDLE, busy stays 0) and sets sticky cfg_err; cleared by clear, rst, or a legal start.
//  Undefined: no cfg_err port; rollover_val is clamped to MAX_ROUNDS and start proceeds.
// TESTING
//  1. rst high mid-RUN (count=5) -> outputs at reset values immediately, async.
//  2. Up, rv=10, enable=1 -> counts 0..10, first_round at 0, last_round at 10, done 1 cycle,
//     cnt_rollover=1 until next start.
//  3. Down, rv=14, enable toggled 1/0 -> counts 14..0 only on enabled cycles, done after
//     15 enabled cycles, round_count=0 after DONE.
//  4. clear at count=3 together with start -> IDLE, count 0, no done, start ignored.
//  5. start during RUN -> ignored; rv=0 start -> done after one enabled cycle.
//  6. rv=15 with MAX_ROUNDS=14: ERR_EN -> start rejected, cfg_err=1; else runs 0..14.

Source files
------------

// File: rtl/flex_round_counter.sv
// Round sequencer for the cipher datapath: latches a round count at start, steps up
// (encrypt) or down (decrypt) once per enabled cycle, flags first/last round and signals
// completion with a one-cycle done pulse plus a sticky rollover flag.
// Optional feature macro: ROUND_CNT_ERR_EN. When defined, an out-of-range rollover_val
// rejects the start and raises sticky cfg_err. When undefined, rollover_val is clamped
// to MAX_ROUNDS.
module flex_round_counter #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned MAX_ROUNDS = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] rollover_val,
  input  logic             count_enable,
  output logic [WIDTH-1:0] round_count,
  output logic             first_round,
  output logic             last_round,
  output logic             busy,
  output logic             done,
  output logic             cnt_rollover
`ifdef ROUND_CNT_ERR_EN
  ,
  output logic             cfg_err
`endif
);

  localparam logic [WIDTH-1:0] MaxRv = WIDTH'(MAX_ROUNDS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] rv_q, rv_d;
  logic             dir_q, dir_d;
  logic             roll_q, roll_d;

  logic             rv_too_big;
  logic             reject;
  logic [WIDTH-1:0] rv_clamped;
  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] term_val;
  logic             at_terminal;

  assign rv_too_big = rollover_val > MaxRv;
  assign rv_clamped = rv_too_big ? MaxRv : rollover_val;

`ifdef ROUND_CNT_ERR_EN
  assign reject = rv_too_big;
`else
  assign reject = 1'b0;
`endif

  // Start and terminal values depend on the direction latched for this sequence.
  assign start_val   = dir_q ? rv_q : '0;
  assign term_val    = dir_q ? '0 : rv_q;
  assign at_terminal = (count_q == term_val);

  // Next-state logic: clear overrides everything; start is only honoured in idle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rv_d    = rv_q;
    dir_d   = dir_q;
    roll_d  = roll_q;
    if (clear) begin
      state_d = StIdle;
      count_d = '0;
      roll_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && !reject) begin
            rv_d    = rv_clamped;
            dir_d   = dir;
            count_d = dir ? rv_clamped : '0;
            roll_d  = 1'b0;
            state_d = StRun;
          end
        end
        StRun: begin
          if (count_enable) begin
            // Terminal is checked before stepping, so the count never wraps.
            if (at_terminal) begin
              state_d = StDone;
              roll_d  = 1'b1;
            end else if (dir_q) begin
              count_d = count_q - 1'b1;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          count_d = '0;
        end
        default: begin
          state_d = StIdle;
          count_d = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      rv_q    <= '0;
      dir_q   <= 1'b0;
      roll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rv_q    <= rv_d;
      dir_q   <= dir_d;
      roll_q  <= roll_d;
    end
  end

`ifdef ROUND_CNT_ERR_EN
  logic err_q, err_d;

  // Sticky config error: set by a rejected start, cleared by clear or a legal start.
  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if ((state_q == StIdle) && start) begin
      err_d = reject;
    end
  end

  // Config error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cfg_err = err_q;
`endif

  assign round_count  = count_q;
  assign first_round  = (state_q == StRun) && (count_q == start_val);
  assign last_round   = (state_q == StRun) && at_terminal;
  assign busy         = (state_q == StRun) || (state_q == StDone);
  assign done         = (state_q == StDone);
  assign cnt_rollover = roll_q;

endmodule

// File: tb/tb_flex_round_counter.sv
// Self-checking bench for flex_round_counter: a sequence-level model (length, direction,
// steps taken) is compared against the DUT on every falling edge, with directed literal
// checks at key points of each scenario.
module tb_flex_round_counter;

  localparam int W    = 4;
  localparam int MAXR = 14;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         start = 1'b0;
  logic         dir = 1'b0;
  logic         count_enable = 1'b0;
  logic [W-1:0] rollover_val = '0;
  logic [W-1:0] round_count;
  logic         first_round, last_round, busy, done, cnt_rollover;
`ifdef ROUND_CNT_ERR_EN
  logic         cfg_err;
`endif

  int checks = 0;
  int errors = 0;

  flex_round_counter #(
    .WIDTH     (W),
    .MAX_ROUNDS(MAXR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .start       (start),
    .dir         (dir),
    .rollover_val(rollover_val),
    .count_enable(count_enable),
    .round_count (round_count),
    .first_round (first_round),
    .last_round  (last_round),
    .busy        (busy),
    .done        (done),
    .cnt_rollover(cnt_rollover)
`ifdef ROUND_CNT_ERR_EN
    ,
    .cfg_err     (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running sequence is described by its length, direction and steps taken.
  int m_len;
  int m_steps;
  bit m_dir, m_run, m_fin, m_roll, m_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_fin = 0; m_steps = 0; m_roll = 0; m_err = 0; m_len = 0; m_dir = 0;
    end else if (clear) begin
      m_run = 0; m_fin = 0; m_steps = 0; m_roll = 0; m_err = 0;
    end else if (m_fin) begin
      m_fin = 0; m_steps = 0;
    end else if (m_run) begin
      if (count_enable) begin
        if (m_steps == m_len) begin
          m_run = 0; m_fin = 1; m_roll = 1;
        end else begin
          m_steps++;
        end
      end
    end else if (start) begin
`ifdef ROUND_CNT_ERR_EN
      if (int'(rollover_val) > MAXR) begin
        m_err = 1;
      end else begin
        m_len = int'(rollover_val); m_dir = dir; m_run = 1; m_steps = 0; m_roll = 0;
        m_err = 0;
      end
`else
      m_len = (int'(rollover_val) > MAXR) ? MAXR : int'(rollover_val);
      m_dir = dir; m_run = 1; m_steps = 0; m_roll = 0;
`endif
    end
  end

  function automatic int exp_count();
    if (!(m_run || m_fin)) return 0;
    return m_dir ? (m_len - m_steps) : m_steps;
  endfunction

  // Compare every cycle on the falling edge, away from the active edge.
  always @(negedge clk) begin
    check("round_count", 32'(round_count), 32'(exp_count()));
    check("first_round", 32'(first_round), 32'(m_run && (m_steps == 0)));
    check("last_round", 32'(last_round), 32'(m_run && (m_steps == m_len)));
    check("busy", 32'(busy), 32'(m_run || m_fin));
    check("done", 32'(done), 32'(m_fin));
    check("cnt_rollover", 32'(cnt_rollover), 32'(m_roll));
`ifdef ROUND_CNT_ERR_EN
    check("cfg_err", 32'(cfg_err), 32'(m_err));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input logic d, input int rv, input logic en);
    dir = d; rollover_val = W'(rv); count_enable = en; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("lit_reset_count", 32'(round_count), 0);
    check("lit_reset_busy", 32'(busy), 0);
    check("lit_reset_roll", 32'(cnt_rollover), 0);

    // Up count to 10.
    go(1'b0, 10, 1'b1);
    check("lit_up_first_cnt", 32'(round_count), 0);
    check("lit_up_first_flag", 32'(first_round), 1);
    for (int i = 0; i < 10; i++) tick();
    check("lit_up_last_cnt", 32'(round_count), 10);
    check("lit_up_last_flag", 32'(last_round), 1);
    tick();
    check("lit_up_done", 32'(done), 1);
    tick();
    check("lit_up_busy_fall", 32'(busy), 0);
    check("lit_up_roll_sticky", 32'(cnt_rollover), 1);
    check("lit_up_cnt_idle", 32'(round_count), 0);
    tick();

    // Down from 14 with enable toggling.
    go(1'b1, 14, 1'b0);
    check("lit_dn_start", 32'(round_count), 14);
    check("lit_dn_roll_clr", 32'(cnt_rollover), 0);
    for (int k = 0; k < 29; k++) begin
      count_enable = (k % 2 == 0);
      tick();
    end
    check("lit_dn_done", 32'(done), 1);
    check("lit_dn_cnt", 32'(round_count), 0);
    count_enable = 1'b0;
    tick();
    check("lit_dn_idle", 32'(busy), 0);

    // Clear together with start at count 3.
    go(1'b0, 8, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    check("lit_clr_pre", 32'(round_count), 3);
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    check("lit_clr_busy", 32'(busy), 0);
    check("lit_clr_cnt", 32'(round_count), 0);
    tick();
    check("lit_clr_nostart", 32'(busy), 0);
    check("lit_clr_nodone", 32'(done), 0);

    // Start during run is ignored.
    go(1'b0, 6, 1'b1);
    tick();
    tick();
    dir = 1'b1; rollover_val = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    check("lit_ign_cnt", 32'(round_count), 3);
    for (int i = 0; i < 6; i++) tick();

    // Zero-length sequence.
    go(1'b0, 0, 1'b0);
    check("lit_zero_first", 32'(first_round), 1);
    check("lit_zero_last", 32'(last_round), 1);
    tick();
    check("lit_zero_stall", 32'(done), 0);
    count_enable = 1'b1;
    tick();
    check("lit_zero_done", 32'(done), 1);
    tick();

    // Out-of-range rollover value.
    go(1'b0, 15, 1'b1);
`ifdef ROUND_CNT_ERR_EN
    check("lit_err_busy", 32'(busy), 0);
    check("lit_err_flag", 32'(cfg_err), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("lit_err_clr", 32'(cfg_err), 0);
`else
    check("lit_clamp_start", 32'(busy), 1);
    for (int i = 0; i < 14; i++) tick();
    check("lit_clamp_cnt", 32'(round_count), 14);
    check("lit_clamp_last", 32'(last_round), 1);
    tick();
    check("lit_clamp_done", 32'(done), 1);
    tick();
`endif

    // Asynchronous reset mid-run at count 5.
    go(1'b0, 12, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("lit_rst_pre", 32'(round_count), 5);
    #1 rst = 1'b1;
    #1;
    check("lit_rst_cnt", 32'(round_count), 0);
    check("lit_rst_busy", 32'(busy), 0);
    check("lit_rst_first", 32'(first_round), 0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
